// File: rtl/jtag_dr_bank.sv
// JTAG debug data-register bank: one capture/shift/update chain per mapped
// instruction, each with its own active length, plus a one-bit bypass chain
// for unmapped codes. Completed updates are offered on a valid/ready action
// port. The overrun flag is sticky and records an update that had to be dropped.
module jtag_dr_bank #(
  parameter int IR_W = 2,
  parameter int N_CH = 4,
  parameter int DR_W = 38,
  parameter logic [8*N_CH-1:0] CH_LEN = {8'd16, 8'd38, 8'd38, 8'd36}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ir_valid,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 capture,
  input  logic                 shift,
  input  logic                 update,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic [N_CH*DR_W-1:0] cap_data,
  output logic                 act_valid,
  output logic [IR_W-1:0]      act_ch,
  output logic [DR_W-1:0]      act_data,
  input  logic                 act_ready,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  logic [DR_W-1:0] sr_q, sr_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            between_q, between_d;
  logic            act_valid_q, act_valid_d;
  logic [IR_W-1:0] act_ch_q, act_ch_d;
  logic [DR_W-1:0] act_data_q, act_data_d;
  logic            overrun_q, overrun_d;

  logic            bypass;
  logic [7:0]      lenSel;
  int              lenInt;
  logic [DR_W-1:0] capSel;
  logic [DR_W-1:0] lenMask;
  logic [DR_W-1:0] shifted;
  logic [DR_W-1:0] shiftVal;
  logic            setOverrun;

  // Decode the current instruction into its chain length and capture slice.
  // Unmapped codes fall through to a one-bit bypass chain.
  always_comb begin
    lenSel = 8'd1;
    capSel = '0;
    bypass = (int'(ir_q) >= N_CH);
    for (int c = 0; c < N_CH; c++) begin
      if (int'(ir_q) == c) begin
        lenSel = CH_LEN[c*8 +: 8];
        capSel = cap_data[c*DR_W +: DR_W];
      end
    end
    lenInt = int'(lenSel);
  end

  // Build the active-length mask and the shifted register image. Only bits
  // below the active length move; the top active bit takes tdi.
  always_comb begin
    lenMask  = '0;
    shiftVal = '0;
    shifted  = {1'b0, sr_q[DR_W-1:1]};
    for (int i = 0; i < DR_W; i++) begin
      lenMask[i] = (i < lenInt);
      if (i == lenInt - 1) begin
        shiftVal[i] = tdi;
      end else if (i < lenInt - 1) begin
        shiftVal[i] = shifted[i];
      end else begin
        shiftVal[i] = sr_q[i];
      end
    end
  end

  // Shift-register control. ir_valid beats capture, and capture beats shift.
  // A capture after a shift is ignored until an update closes the scan.
  always_comb begin
    sr_d      = sr_q;
    ir_d      = ir_q;
    between_d = between_q;
    if (ir_valid) begin
      ir_d      = ir_in;
      between_d = 1'b0;
    end else if (capture) begin
      if (!between_q) begin
        sr_d = bypass ? '0 : (capSel & lenMask);
      end
    end else if (shift) begin
      sr_d      = shiftVal;
      between_d = 1'b1;
    end
    if (update) begin
      between_d = 1'b0;
    end
  end

  // Action port and overrun flag. An update sees the pre-shift register.
  // It is accepted only when the slot is free or is being drained this cycle.
  always_comb begin
    act_valid_d = act_valid_q;
    act_ch_d    = act_ch_q;
    act_data_d  = act_data_q;
    overrun_d   = overrun_q;
    setOverrun  = 1'b0;
    if (update && !bypass) begin
      if (!act_valid_q || act_ready) begin
        act_valid_d = 1'b1;
        act_ch_d    = ir_q;
        act_data_d  = sr_q & lenMask;
      end else begin
        setOverrun = 1'b1;
      end
    end else if (act_valid_q && act_ready) begin
      act_valid_d = 1'b0;
    end
    if (setOverrun) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Scan-side state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q      <= '0;
      ir_q      <= '0;
      between_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      ir_q      <= ir_d;
      between_q <= between_d;
    end
  end

  // Action-side state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_valid_q <= 1'b0;
      act_ch_q    <= '0;
      act_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      act_valid_q <= act_valid_d;
      act_ch_q    <= act_ch_d;
      act_data_q  <= act_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tdo       = sr_q[0];
  assign act_valid = act_valid_q;
  assign act_ch    = act_ch_q;
  assign act_data  = act_data_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/jtag_dr_bank.md
Name: jtag_dr_bank

Overview:
- Parametrised JTAG debug data-register bank: per-instruction capture/shift/update chains with per-channel shift length, in the system clock domain.
- Successor to the fixed 2-bit-IR/38-bit debug register: channel count, IR width, DR width and per-channel length are parameters.
- Adds a valid/ready action handshake with a sticky overrun flag and a bypass chain for unmapped IR codes.
- Sits between the JTAG event synchroniser (single-cycle strobes in clk domain) and the CPU OCI/trace/break logic.

Parameters:
IR_W, 2, instruction register width
N_CH, 4, number of mapped channels; 1..2**IR_W; codes >= N_CH select bypass
DR_W, 38, physical shift register width
CH_LEN, {8'd16,8'd38,8'd38,8'd36}, packed 8-bit active lengths, channel 0 in bits [7:0]; each 1..DR_W

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
ir_valid  in  1  update-IR strobe, one cycle
ir_in  in  IR_W  new instruction, sampled when ir_valid=1
capture  in  1  capture-DR strobe
shift  in  1  shift-DR strobe, one bit per asserted cycle
update  in  1  update-DR strobe
tdi  in  1  serial data in, sampled when shift=1
tdo  out  1  serial data out, equals sr[0]
cap_data  in  N_CH*DR_W  capture values, channel c at [c*DR_W +: DR_W]
act_valid  out  1  action pending
act_ch  out  IR_W  channel of pending action
act_data  out  DR_W  updated DR contents, bits >= L zero
act_ready  in  1  consumer accepts action
overrun  out  1  sticky: update arrived while action still pending
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (async, immediate): sr=0, ir=0, act_valid=0, act_ch=0, act_data=0, overrun=0, between=0; tdo=0.
- L = CH_LEN[ir*8 +: 8] for ir<N_CH; L=1 in bypass.
- Control priority when strobes coincide: ir_valid > capture > shift. update is evaluated in parallel.
- ir_valid: ir<=ir_in and between<=0. sr is not modified.
- capture:
  - Ignored while between=1.
  - Otherwise sr[L-1:0]<=cap_data slice[L-1:0] and sr[DR_W-1:L]<=0.
  - Bypass: sr<=0.
- shift: sr[L-1]<=tdi; sr[L-2:0]<=sr[L-1:1]; bits >= L hold; between<=1.
  - For L=1, sr[0]<=tdi.
  - tdo updates the cycle after each shift.
- update:
  - Uses sr as it was before any same-cycle shift.
  - Clears between.
  - Bypass: no action.
- Action register (mapped channel, update=1):
  - If act_valid=0, or act_valid&act_ready in the same cycle: next cycle act_valid=1, act_ch=ir, act_data=sr masked to L. Latency is exactly 1 cycle.
  - Else: act_* hold their values and overrun<=1.
- act_valid&act_ready with no accepting update: act_valid<=0; act_ch/act_data hold.
- overrun: set has priority over clr_overrun in the same cycle. Cleared only by clr_overrun or reset.
- Reset mid-shift: the partial shift is discarded, and the next capture is honoured because between=0.
- act_valid must not drop without act_ready.
- act_data/act_ch must stay stable while act_valid=1 and act_ready=0.

Test Plan:
- Reset, ir_valid with ir_in=2'b00, capture with ch0 cap_data=36'h9_8765_4321, 36 shifts with tdi=0 -> tdo sequence LSB-first 1,0,0,0,0,1,0,0,...; sr[37:36] remain 0.
- ch3 (L=16): capture 16'hA5C3, shift 16 bits of 16'h1234 LSB-first, update with act_ready=1 -> act_valid=1 exactly one cycle after update, act_ch=3, act_data=38'h1234; tdo stream = 16'hA5C3 LSB-first.
- act_ready held 0, two updates on ch1 with data 38'h1 then 38'h2 -> act_data stays 38'h1 and overrun=1; assert act_ready -> act_valid drops; clr_overrun -> overrun=0.
- Update and act_ready asserted in the same cycle with act_valid=1 -> no overrun; act_data changes to the new value with act_valid continuously 1.
- Capture issued after a shift but before update -> sr unchanged; after update, a second capture loads the new cap_data.
- N_CH=3, ir_in=2'b11 (bypass): shift tdi=1,0,1 -> tdo=1,0,1 with one-cycle lag; update -> act_valid stays 0; async reset asserted mid-shift -> tdo=0, act_valid=0 immediately.
